// File: rtl/hit_score_pvp_if.sv
// Bundle of game-side signals between the bullet/player logic and the hit/score block.
// The master drives positions and bullets. The slave returns lives, pulses and game status.
interface hit_score_pvp_if #(
    parameter int NUM_BULLETS = 4
);
    logic                     frame_tick;
    logic                     start_game;
    logic [10*NUM_BULLETS-1:0] bullet1X;
    logic [10*NUM_BULLETS-1:0] bullet1Y;
    logic [NUM_BULLETS-1:0]   bullet1_active;
    logic [10*NUM_BULLETS-1:0] bullet2X;
    logic [10*NUM_BULLETS-1:0] bullet2Y;
    logic [NUM_BULLETS-1:0]   bullet2_active;
    logic [9:0]               player1X;
    logic [9:0]               player1Y;
    logic [9:0]               player2X;
    logic [9:0]               player2Y;
    logic [2:0]               lives_p1;
    logic [2:0]               lives_p2;
    logic                     hit_p1;
    logic                     hit_p2;
    logic [NUM_BULLETS-1:0]   clear1;
    logic [NUM_BULLETS-1:0]   clear2;
    logic                     invuln_p1;
    logic                     invuln_p2;
    logic                     round_reset;
    logic                     game_over;
    logic [1:0]               winner;

    modport master (
        output frame_tick, start_game,
        output bullet1X, bullet1Y, bullet1_active,
        output bullet2X, bullet2Y, bullet2_active,
        output player1X, player1Y, player2X, player2Y,
        input  lives_p1, lives_p2, hit_p1, hit_p2, clear1, clear2,
        input  invuln_p1, invuln_p2, round_reset, game_over, winner
    );

    modport slave (
        input  frame_tick, start_game,
        input  bullet1X, bullet1Y, bullet1_active,
        input  bullet2X, bullet2Y, bullet2_active,
        input  player1X, player1Y, player2X, player2Y,
        output lives_p1, lives_p2, hit_p1, hit_p2, clear1, clear2,
        output invuln_p1, invuln_p2, round_reset, game_over, winner
    );
endinterface

// File: rtl/hit_score_pvp.sv
// Two-player bullet/hitbox collision, lives, frame-timed invulnerability and IDLE/PLAY/OVER game control.
// Every output is a register; hits seen at edge n appear after edge n+1.
module hit_score_pvp #(
    parameter int PLAYER_SIZE   = 16,
    parameter int NUM_BULLETS   = 4,
    parameter int START_LIVES   = 3,
    parameter int INVULN_FRAMES = 60
) (
    input logic              Clk,
    input logic              Reset,
    hit_score_pvp_if.slave   bus
);
    localparam int CW = $clog2(INVULN_FRAMES + 1);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER} state_t;

    state_t                 r_state;
    logic [2:0]             r_lives1, r_lives2;
    logic                   r_hit1, r_hit2;
    logic [NUM_BULLETS-1:0] r_clear1, r_clear2;
    logic                   r_inv1, r_inv2;
    logic [CW-1:0]          r_cnt1, r_cnt2;
    logic                   r_round;
    logic                   r_over;
    logic [1:0]             r_winner;

    logic [NUM_BULLETS-1:0] w_ov1;   // player-1 bullets overlapping player 2
    logic [NUM_BULLETS-1:0] w_ov2;   // player-2 bullets overlapping player 1
    logic                   w_hit1, w_hit2;
    logic                   w_dead1, w_dead2;

    // Far edges use 11-bit sums so a hitbox near x/y = 1023 does not wrap to 0.
    function automatic logic overlap(input logic act, input logic [9:0] bx, input logic [9:0] by,
                                     input logic [9:0] px, input logic [9:0] py);
        logic [10:0] xe;
        logic [10:0] ye;
        xe = {1'b0, px} + 11'(PLAYER_SIZE);
        ye = {1'b0, py} + 11'(PLAYER_SIZE);
        return act && (bx >= px) && ({1'b0, bx} < xe) && (by >= py) && ({1'b0, by} < ye);
    endfunction

    always_comb begin
        w_ov1 = '0;
        w_ov2 = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            w_ov1[i] = overlap(bus.bullet1_active[i], bus.bullet1X[10*i +: 10], bus.bullet1Y[10*i +: 10],
                               bus.player2X, bus.player2Y);
            w_ov2[i] = overlap(bus.bullet2_active[i], bus.bullet2X[10*i +: 10], bus.bullet2Y[10*i +: 10],
                               bus.player1X, bus.player1Y);
        end
    end

    assign w_hit1  = (r_state == S_PLAY) && (|w_ov2) && !r_inv1;
    assign w_hit2  = (r_state == S_PLAY) && (|w_ov1) && !r_inv2;
    assign w_dead1 = w_hit1 && (r_lives1 == 3'd1);
    assign w_dead2 = w_hit2 && (r_lives2 == 3'd1);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_lives1 <= 3'(START_LIVES);
            r_lives2 <= 3'(START_LIVES);
            r_hit1   <= 1'b0;
            r_hit2   <= 1'b0;
            r_clear1 <= '0;
            r_clear2 <= '0;
            r_inv1   <= 1'b0;
            r_inv2   <= 1'b0;
            r_cnt1   <= '0;
            r_cnt2   <= '0;
            r_round  <= 1'b0;
            r_over   <= 1'b0;
            r_winner <= 2'b00;
        end else begin
            r_hit1   <= 1'b0;
            r_hit2   <= 1'b0;
            r_clear1 <= '0;
            r_clear2 <= '0;
            r_round  <= 1'b0;
            case (r_state)
                S_IDLE, S_OVER: begin
                    if (bus.start_game) begin
                        r_state  <= S_PLAY;
                        r_round  <= 1'b1;
                        r_lives1 <= 3'(START_LIVES);
                        r_lives2 <= 3'(START_LIVES);
                        r_inv1   <= 1'b0;
                        r_inv2   <= 1'b0;
                        r_cnt1   <= '0;
                        r_cnt2   <= '0;
                        r_over   <= 1'b0;
                        r_winner <= 2'b00;
                    end
                end
                S_PLAY: begin
                    // A fresh hit reloads the timer even if frame_tick arrives in the same cycle.
                    if (w_hit1) begin
                        r_hit1   <= 1'b1;
                        r_lives1 <= r_lives1 - 3'd1;
                        r_inv1   <= 1'b1;
                        r_cnt1   <= CW'(INVULN_FRAMES);
                        r_clear2 <= w_ov2;
                    end else if (r_inv1) begin
                        if (r_cnt1 == '0)
                            r_inv1 <= 1'b0;
                        else if (bus.frame_tick)
                            r_cnt1 <= r_cnt1 - CW'(1);
                    end

                    if (w_hit2) begin
                        r_hit2   <= 1'b1;
                        r_lives2 <= r_lives2 - 3'd1;
                        r_inv2   <= 1'b1;
                        r_cnt2   <= CW'(INVULN_FRAMES);
                        r_clear1 <= w_ov1;
                    end else if (r_inv2) begin
                        if (r_cnt2 == '0)
                            r_inv2 <= 1'b0;
                        else if (bus.frame_tick)
                            r_cnt2 <= r_cnt2 - CW'(1);
                    end

                    // winner bit 1 = P2 wins (P1 died), bit 0 = P1 wins (P2 died).
                    if (w_dead1 || w_dead2) begin
                        r_state  <= S_OVER;
                        r_over   <= 1'b1;
                        r_winner <= {w_dead1, w_dead2};
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.lives_p1    = r_lives1;
    assign bus.lives_p2    = r_lives2;
    assign bus.hit_p1      = r_hit1;
    assign bus.hit_p2      = r_hit2;
    assign bus.clear1      = r_clear1;
    assign bus.clear2      = r_clear2;
    assign bus.invuln_p1   = r_inv1;
    assign bus.invuln_p2   = r_inv2;
    assign bus.round_reset = r_round;
    assign bus.game_over   = r_over;
    assign bus.winner      = r_winner;
endmodule

// File: tb/tb_hit_score_pvp.sv
// Directed bench for hit_score_pvp: hits, hitbox edges, invulnerability timing, game end and reset.
module tb_hit_score_pvp;
    logic Clk;
    logic Reset;
    int   total;
    int   bad;

    hit_score_pvp_if #(.NUM_BULLETS(4)) bus ();

    hit_score_pvp #(
        .PLAYER_SIZE(16), .NUM_BULLETS(4), .START_LIVES(3), .INVULN_FRAMES(60)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_b1(input int s, input int x, input int y);
        bus.bullet1X[10*s +: 10] = 10'(x);
        bus.bullet1Y[10*s +: 10] = 10'(y);
        bus.bullet1_active[s]    = 1'b1;
    endtask

    task automatic set_b2(input int s, input int x, input int y);
        bus.bullet2X[10*s +: 10] = 10'(x);
        bus.bullet2Y[10*s +: 10] = 10'(y);
        bus.bullet2_active[s]    = 1'b1;
    endtask

    task automatic clr_bullets();
        bus.bullet1_active = '0;
        bus.bullet2_active = '0;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            bus.frame_tick = 1'b1;
            tick();
            bus.frame_tick = 1'b0;
            tick();
        end
    endtask

    task automatic start();
        bus.start_game = 1'b1;
        tick();
        bus.start_game = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        Reset = 1'b1;
        bus.frame_tick = 1'b0;
        bus.start_game = 1'b0;
        bus.bullet1X = '0; bus.bullet1Y = '0; bus.bullet1_active = '0;
        bus.bullet2X = '0; bus.bullet2Y = '0; bus.bullet2_active = '0;
        bus.player1X = 10'd400; bus.player1Y = 10'd400;
        bus.player2X = 10'd100; bus.player2Y = 10'd100;
        tick();
        tick();
        Reset = 1'b0;

        chk("rst_lives1", bus.lives_p1, 3);
        chk("rst_lives2", bus.lives_p2, 3);
        chk("rst_over", bus.game_over, 0);
        chk("rst_winner", bus.winner, 0);
        chk("rst_inv2", bus.invuln_p2, 0);
        chk("rst_rr", bus.round_reset, 0);

        start();
        chk("start_rr", bus.round_reset, 1);
        chk("start_lives1", bus.lives_p1, 3);
        tick();
        chk("start_rr_drop", bus.round_reset, 0);

        // single hit on P2 by P1 slot 2
        set_b1(2, 108, 115);
        tick();
        chk("hit_p2", bus.hit_p2, 1);
        chk("hit_clear1", bus.clear1, 4'b0100);
        chk("hit_lives2", bus.lives_p2, 2);
        chk("hit_inv2", bus.invuln_p2, 1);
        chk("hit_p1_quiet", bus.hit_p1, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_hit2", bus.hit_p2, 0);
            chk("hold_clear1", bus.clear1, 0);
        end
        chk("hold_lives2", bus.lives_p2, 2);
        clr_bullets();

        // hitbox far edges are exclusive
        bus.player1X = 10'd100; bus.player1Y = 10'd100;
        set_b2(0, 116, 100);
        tick();
        chk("edge_x", bus.hit_p1, 0);
        set_b2(0, 100, 116);
        tick();
        chk("edge_y", bus.hit_p1, 0);
        chk("edge_lives1", bus.lives_p1, 3);
        clr_bullets();

        // no wrap near 1023
        bus.player1X = 10'd1010;
        set_b2(1, 1020, 105);
        tick();
        chk("wrap_hit1", bus.hit_p1, 1);
        chk("wrap_lives1", bus.lives_p1, 2);
        chk("wrap_clear2", bus.clear2, 4'b0010);
        clr_bullets();

        pulses(59);
        chk("inv2_still", bus.invuln_p2, 1);
        pulses(1);
        chk("inv2_expired", bus.invuln_p2, 0);
        chk("inv1_expired", bus.invuln_p1, 0);

        // two overlapping slots, single life lost
        set_b1(0, 100, 100);
        set_b1(3, 115, 115);
        tick();
        chk("multi_hit2", bus.hit_p2, 1);
        chk("multi_lives2", bus.lives_p2, 1);
        chk("multi_clear1", bus.clear1, 4'b1001);
        tick();
        chk("pass_hit2", bus.hit_p2, 0);
        chk("pass_clear1", bus.clear1, 0);
        chk("pass_lives2", bus.lives_p2, 1);
        clr_bullets();

        pulses(60);
        set_b2(1, 1020, 105);
        tick();
        chk("p1_to_1", bus.lives_p1, 1);
        clr_bullets();
        pulses(60);

        // simultaneous final hits -> draw
        set_b2(0, 1012, 100);
        set_b1(1, 100, 100);
        tick();
        chk("draw_lives1", bus.lives_p1, 0);
        chk("draw_lives2", bus.lives_p2, 0);
        chk("draw_over", bus.game_over, 1);
        chk("draw_winner", bus.winner, 2'b11);
        chk("draw_hit1", bus.hit_p1, 1);
        chk("draw_hit2", bus.hit_p2, 1);
        tick();
        chk("over_hit1", bus.hit_p1, 0);
        chk("over_lives1", bus.lives_p1, 0);
        chk("over_winner", bus.winner, 2'b11);
        clr_bullets();

        start();
        chk("restart_rr", bus.round_reset, 1);
        chk("restart_lives1", bus.lives_p1, 3);
        chk("restart_lives2", bus.lives_p2, 3);
        chk("restart_winner", bus.winner, 0);
        chk("restart_over", bus.game_over, 0);

        // P2 alone loses all lives
        for (int k = 0; k < 2; k++) begin
            set_b1(0, 105, 105);
            tick();
            chk("solo_lives2", bus.lives_p2, 32'(2 - k));
            clr_bullets();
            pulses(60);
        end
        set_b1(0, 105, 105);
        tick();
        chk("solo_final_lives2", bus.lives_p2, 0);
        chk("solo_winner", bus.winner, 2'b01);
        chk("solo_over", bus.game_over, 1);
        chk("solo_lives1", bus.lives_p1, 3);
        clr_bullets();

        // reset in PLAY with invuln active
        start();
        set_b1(0, 105, 105);
        tick();
        chk("pre_rst_inv2", bus.invuln_p2, 1);
        chk("pre_rst_lives2", bus.lives_p2, 2);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("mid_rst_lives2", bus.lives_p2, 3);
        chk("mid_rst_inv2", bus.invuln_p2, 0);
        chk("mid_rst_over", bus.game_over, 0);
        tick();
        chk("idle_hit2", bus.hit_p2, 0);
        chk("idle_lives2", bus.lives_p2, 3);
        chk("idle_clear1", bus.clear1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hit_score_pvp.md
Name: hit_score_pvp

Overview:
- Sequential successor to the two-player bullet/player collision check.
- Tests up to NUM_BULLETS bullets per player against the opposing player's hitbox every clock.
- Manages lives and post-hit invulnerability (frame-timed), and a game state machine (IDLE/PLAY/OVER).
- Drives registered hit/clear pulses back to the bullet controllers and game-over/winner to the display logic.

Parameters:
- PLAYER_SIZE, 16: square hitbox side in pixels.
- NUM_BULLETS, 4: bullet slots per player.
- START_LIVES, 3: lives loaded at game start; must be 1..7.
- INVULN_FRAMES, 60: frame_tick count a player is immune after losing a life; must be >= 1.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle pulse per video frame (vsync-derived)
- start_game  in  1  level or pulse; sampled each clock
- bullet1X, bullet1Y  in  10*NUM_BULLETS each  player-1 bullet coords; slot i = bits [10i+9:10i]
- bullet1_active  in  NUM_BULLETS  player-1 slot valid
- bullet2X, bullet2Y, bullet2_active  in  same widths  player-2 bullets
- player1X, player1Y, player2X, player2Y  in  10 each  hitbox top-left corners
- lives_p1, lives_p2  out  3 each  remaining lives
- hit_p1, hit_p2  out  1  one-cycle pulse when that player loses a life
- clear1, clear2  out  NUM_BULLETS  one-cycle per-slot pulse telling the owner's bullet controller to deactivate a bullet (clear1 = player-1 bullets)
- invuln_p1, invuln_p2  out  1  player currently immune
- round_reset  out  1  one-cycle pulse on every entry into PLAY
- game_over  out  1  high in OVER
- winner  out  2  01 = P1, 10 = P2, 11 = draw, 00 = none

Behaviour:
- All outputs are registered. On Reset:
  - state = IDLE
  - lives = START_LIVES
  - all pulses, invuln flags, invuln counters, game_over and winner = 0
- Overlap test (combinational, internal):
  - Bullet b hits player P when active, x >= PX, x < PX + PLAYER_SIZE, y >= PY, y < PY + PLAYER_SIZE.
  - Sums are computed 11 bits wide, so the test does not wrap at 1023.
  - A player's own bullets never hit that player.
- IDLE:
  - No hit processing.
  - start_game = 1 -> PLAY. The next cycle has round_reset = 1, lives reloaded, invuln cleared.
- PLAY, evaluated per player each clock. "Any overlap" = any opposing bullet overlaps the player.
  - Any overlap and not invuln:
    - Next cycle: hit_pX = 1 and lives decrement by exactly 1, regardless of how many bullets overlap.
    - All overlapping opposing slots pulse in clearY.
    - invuln set; counter loaded with INVULN_FRAMES.
  - Any overlap while invuln: ignored; no hit, no decrement, no clear (the bullet passes through).
  - Invuln counter decrements on each frame_tick. invuln drops the cycle after the counter reaches 0.
  - Both players are hit in the same cycle: both are processed independently in the same cycle.
  - A decrement that brings a player's lives to 0 -> OVER next cycle.
    - winner = the opponent, or 11 if both reach 0 in the same cycle.
  - start_game is ignored in PLAY.
- OVER:
  - game_over = 1; lives and winner held; no hit processing; invuln counters frozen.
  - start_game = 1 -> PLAY: round_reset pulse, lives = START_LIVES, winner = 0, game_over = 0, invuln cleared.
- Latency: overlap present at clock edge n -> hit/clear/lives visible after edge n+1. Pulses last exactly 1 cycle.
  - If overlap persists, no second hit is taken: invuln is already set by then.
- Reset mid-game (any state) returns to the reset values above at the next edge.
- frame_tick coinciding with a hit: the reload wins; the counter = INVULN_FRAMES.

Test Plan:
1. Reset, start_game pulse -> round_reset = 1 for 1 cycle, lives_p1 = lives_p2 = 3, state PLAY.
2. Single hit:
   - Stimulus: player2 at (100,100); bullet1 slot 2 active at (108,115).
   - Response: next cycle hit_p2 = 1, clear1 = 4'b0100, lives_p2 = 2, invuln_p2 = 1.
   - Bullet held 10 more cycles -> no further hit.
3. Hitbox edges and invuln expiry:
   - Bullet at (116,100) or (100,116) with player at (100,100) -> no hit.
   - Player at (1010,100), bullet at (1020,105) -> hit (no wrap).
   - After 60 frame_ticks invuln_p2 = 0, and a re-hit decrements again.
4. Multiple bullets: bullet1 slots 0 and 3 overlap player2 in the same cycle -> lives_p2 decrements by 1 only, clear1 = 4'b1001.
5. Game end:
   - Both players at 1 life, hit simultaneously -> both lives 0, state OVER, game_over = 1, winner = 11.
   - start_game -> lives 3, winner 00, round_reset pulse.
   - Separately, P2 alone reaching 0 -> winner = 01.
6. Reset asserted in PLAY with invuln active -> next cycle IDLE, lives 3, invuln 0, game_over 0; overlapping bullets produce no hit in IDLE.
